// File: rtl/card_shuffler.sv
// card_shuffler: Fisher-Yates deck shuffler with bounded rejection sampling.
// Define SHUFFLE_PAIRS_EN to load the deck as value pairs (k>>1) instead of identity.
module card_shuffler #(
    parameter int NUM_CARDS = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      random_number,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             deck_valid,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [IDX_W-1:0] rd_data
);
    typedef enum logic [1:0] {IDLE, INIT, PICK, DONE} state_t;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CARDS - 1);
    localparam logic [IDX_W-1:0] ONE = IDX_W'(1);
    state_t state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d, i_q, i_d, mask, s, j;
    logic [2:0] retry_q, retry_d;
    logic deck_valid_q, deck_valid_d, accept;
    logic [IDX_W-1:0] deck_q [NUM_CARDS];
    logic [IDX_W-1:0] deck_d [NUM_CARDS];
    logic unused_rnd;

    function automatic logic [IDX_W-1:0] init_val(input logic [IDX_W-1:0] n);
`ifdef SHUFFLE_PAIRS_EN
        return n >> 1;
`else
        return n;
`endif
    endfunction

    assign unused_rnd = ^random_number[31:IDX_W];
    assign busy = state_q == INIT || state_q == PICK;
    assign done = state_q == DONE;
    assign deck_valid = deck_valid_q;
    assign rd_data = deck_q[rd_addr];

    // mask smears the top set bit of i downwards; the forced pick drops the top bit so j <= i
    always_comb begin
        mask = '0;
        for (int b = 0; b < IDX_W; b++) mask = mask | (i_q >> b);
        s = random_number[IDX_W-1:0] & mask;
        accept = s <= i_q || retry_q == 3'd7;
        j = s <= i_q ? s : s & (mask >> 1);
    end

    always_comb begin
        state_d = state_q;
        k_d = k_q;
        i_d = i_q;
        retry_d = retry_q;
        deck_valid_d = deck_valid_q;
        deck_d = deck_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = INIT;
                k_d = '0;
                deck_valid_d = 1'b0;
            end
            INIT: begin
                deck_d[k_q] = init_val(k_q);
                k_d = k_q + ONE;
                if (k_q == LAST) begin
                    state_d = PICK;
                    i_d = LAST;
                    retry_d = '0;
                end
            end
            PICK: if (accept) begin
                deck_d[i_q] = deck_q[j];
                deck_d[j] = deck_q[i_q];
                i_d = i_q - ONE;
                retry_d = '0;
                if (i_q == ONE) begin
                    state_d = DONE;
                    deck_valid_d = 1'b1;
                end
            end else begin
                retry_d = retry_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q <= '0;
            i_q <= '0;
            retry_q <= '0;
            deck_valid_q <= 1'b0;
            for (int n = 0; n < NUM_CARDS; n++) deck_q[n] <= init_val(IDX_W'(n));
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            i_q <= i_d;
            retry_q <= retry_d;
            deck_valid_q <= deck_valid_d;
            deck_q <= deck_d;
        end
    end
endmodule

// File: tb/tb_card_shuffler.sv
// tb_card_shuffler: random-stimulus bench for card_shuffler against a Fisher-Yates reference model.
module tb_card_shuffler;
    localparam int N = 16;
    localparam int W = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [31:0] random_number = '0;
    logic busy, done, deck_valid;
    logic [W-1:0] rd_addr = '0;
    logic [W-1:0] rd_data;
    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int lat;
    logic [31:0] words[$];
    int exp_deck[N];

    card_shuffler #(.NUM_CARDS(N), .IDX_W(W)) dut (
        .clk(clk),
        .reset(reset),
        .random_number(random_number),
        .start(start),
        .busy(busy),
        .done(done),
        .deck_valid(deck_valid),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int init_val(input int n);
`ifdef SHUFFLE_PAIRS_EN
        return n / 2;
`else
        return n;
`endif
    endfunction

    function automatic logic [31:0] word(input int mode);
        return mode == 0 ? 32'h0 : mode == 1 ? 32'hFFFF_FFFF : $urandom;
    endfunction

    // Replays the recorded words: the first N edges load the deck, then one draw per PICK cycle.
    // Fills exp_deck and returns the expected latency in edges, counting the start edge as 1.
    function automatic int model();
        int d[N];
        int idx = N;
        for (int n = 0; n < N; n++) d[n] = init_val(n);
        for (int i = N - 1; i >= 1; i--) begin
            int size = 1;
            int j = -1;
            int t;
            while (size <= i) size *= 2;
            for (int r = 0; r < 8 && j < 0; r++) begin
                int s = idx < words.size() ? int'(words[idx] % size) : 0;
                idx++;
                if (s <= i) j = s;
                else if (r == 7) j = s % (size / 2);
            end
            t = d[i];
            d[i] = d[j];
            d[j] = t;
        end
        exp_deck = d;
        return idx + 1;
    endfunction

    task automatic check_deck(input string tag);
        for (int a = 0; a < N; a++) begin
            rd_addr = W'(a);
            #1;
            chk($sformatf("%s deck[%0d]", tag, a), rd_data, exp_deck[a]);
        end
    endtask

    task automatic load_init();
        for (int n = 0; n < N; n++) exp_deck[n] = init_val(n);
    endtask

    task automatic shuffle(input int mode, input bit poke, input string tag, output int l);
        int exp_lat;
        words.delete();
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        l = 1;
        chk({tag, " busy"}, busy, 1);
        chk({tag, " valid_clr"}, deck_valid, 0);
        while (done !== 1'b1 && l < 400) begin
            random_number = word(mode);
            words.push_back(random_number);
            if (poke) start = $urandom_range(0, 3) == 0;
            @(negedge clk);
            l++;
        end
        start = poke;
        exp_lat = model();
        chk({tag, " lat"}, l, exp_lat);
        chk({tag, " valid_at_done"}, deck_valid, 1);
        @(negedge clk);
        start = 1'b0;
        chk({tag, " done_pulse"}, done, 0);
        chk({tag, " idle"}, busy, 0);
        chk({tag, " valid_hold"}, deck_valid, 1);
        repeat (4) begin
            random_number = $urandom;
            @(negedge clk);
        end
        check_deck(tag);
        chk({tag, " done_cnt"}, done_cnt, 1);
    endtask

    task automatic abort_test();
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) begin
            random_number = $urandom;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort valid", deck_valid, 0);
        load_init();
        check_deck("abort");
        repeat (60) begin
            random_number = $urandom;
            @(negedge clk);
        end
        chk("abort no_done", done_cnt, 0);
        chk("abort still_idle", busy, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst valid", deck_valid, 0);
        load_init();
        check_deck("rst");
        shuffle(0, 1'b0, "zero", lat);
        chk("zero lat_const", lat, 2 * N);
        shuffle(1, 1'b0, "ones", lat);
        chk("ones lat_const", lat, 109);
        shuffle(0, 1'b1, "zero_poke", lat);
        chk("zero_poke lat_const", lat, 2 * N);
        for (int r = 0; r < 12; r++) shuffle(2, 1'($urandom_range(0, 1)), $sformatf("rand%0d", r), lat);
        abort_test();
        shuffle(2, 1'b1, "post_abort", lat);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
